// File: rtl/adc_stream_downsizer_pkg.sv
// Shared widths, data types and FSM encoding for the ADC-to-PS stream width converter.
package adc_pkg;

  localparam int ADC_IN_W  = 128;
  localparam int ADC_PS_W  = 32;
  localparam int ADC_RATIO = ADC_IN_W / ADC_PS_W;

  typedef logic [ADC_IN_W-1:0] adc_beat_t;
  typedef logic [ADC_PS_W-1:0] adc_word_t;

  typedef enum logic {
    DSZ_EMPTY = 1'b0,
    DSZ_DRAIN = 1'b1
  } dsz_state_e;

  // Index width that stays legal (>= 1 bit) when the ratio is 1.
  function automatic int idx_width(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/adc_dsz_skid.sv
// Generic 2-entry AXI-Stream skid buffer with a registered ready.
// Ready is high whenever fewer than two entries are held.
module adc_dsz_skid #(
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] s_tdata,
  input  logic             s_tvalid,
  output logic             s_tready,
  output logic [WIDTH-1:0] m_tdata,
  output logic             m_tvalid,
  input  logic             m_tready
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic [1:0]       count_d;
  logic             ready_q;
  logic             push;
  logic             pop;

  assign push     = s_tvalid & ready_q;
  assign pop      = m_tvalid & m_tready;
  assign m_tvalid = (count_q != 2'd0);
  assign m_tdata  = mem_q[rd_ptr_q];
  assign s_tready = ready_q;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      ready_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_q ^ push;
      rd_ptr_q <= rd_ptr_q ^ pop;
      count_q  <= count_d;
      ready_q  <= (count_d < 2'd2);
    end
  end

  // NOTE: entry storage is not reset; count_q gates its visibility, so resetting it only costs routing.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= s_tdata;
  end

endmodule

// File: rtl/adc_stream_downsizer.sv
// Splits each wide AXIS beat into IN_WIDTH/OUT_WIDTH narrow words, least-significant first.
// Optional packet framing (m_axis_tlast every PKT_WORDS words) is enabled by defining ADC_DSZ_TLAST_EN.
module adc_stream_downsizer
  import adc_pkg::*;
#(
  parameter int IN_WIDTH  = ADC_IN_W,
  parameter int OUT_WIDTH = ADC_PS_W,
  parameter int PKT_WORDS = 1024
) (
  input  logic                 pl_clk,
  input  logic                 rst,
  input  logic [IN_WIDTH-1:0]  s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  output logic [OUT_WIDTH-1:0] m_axis_tdata,
  output logic                 m_axis_tvalid,
`ifdef ADC_DSZ_TLAST_EN
  output logic                 m_axis_tlast,
`endif
  input  logic                 m_axis_tready
);

  localparam int RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int IDX_W = idx_width(RATIO);

  if (IN_WIDTH % OUT_WIDTH != 0) begin : g_bad_ratio
    $error("adc_stream_downsizer: IN_WIDTH must be a multiple of OUT_WIDTH");
  end
  if (PKT_WORDS < 1) begin : g_bad_pkt
    $error("adc_stream_downsizer: PKT_WORDS must be at least 1");
  end

  logic [IN_WIDTH-1:0] skid_data;
  logic                skid_valid;
  logic                skid_pop;

  adc_dsz_skid #(
    .WIDTH(IN_WIDTH)
  ) u_skid (
    .clk      (pl_clk),
    .rst_n    (rst),
    .s_tdata  (s_axis_tdata),
    .s_tvalid (s_axis_tvalid),
    .s_tready (s_axis_tready),
    .m_tdata  (skid_data),
    .m_tvalid (skid_valid),
    .m_tready (skid_pop)
  );

  dsz_state_e                      state_q;
  dsz_state_e                      state_d;
  logic [RATIO-1:0][OUT_WIDTH-1:0] hold_q;
  logic [IDX_W-1:0]                idx_q;
  logic [IDX_W-1:0]                idx_d;
  logic                            out_fire;
  logic                            last_word;
  logic                            load;

  assign m_axis_tvalid = (state_q == DSZ_DRAIN);
  assign out_fire      = m_axis_tvalid & m_axis_tready;
  assign last_word     = (idx_q == IDX_W'(RATIO - 1));
  assign m_axis_tdata  = hold_q[idx_q];
  assign skid_pop      = load;

  // NOTE: every always_comb output is defaulted first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    load    = 1'b0;
    case (state_q)
      DSZ_EMPTY: begin
        if (skid_valid) begin
          load    = 1'b1;
          idx_d   = '0;
          state_d = DSZ_DRAIN;
        end
      end
      DSZ_DRAIN: begin
        if (out_fire) begin
          if (!last_word) begin
            idx_d = idx_q + 1'b1;
          end else if (skid_valid) begin
            // Reload on the final word so back-to-back beats leave no bubble.
            load  = 1'b1;
            idx_d = '0;
          end else begin
            idx_d   = '0;
            state_d = DSZ_EMPTY;
          end
        end
      end
      default: begin
        idx_d   = '0;
        state_d = DSZ_EMPTY;
      end
    endcase
  end

  // HOLD is cleared on reset because its slice drives m_axis_tdata directly.
  always_ff @(posedge pl_clk or negedge rst) begin
    if (!rst) begin
      state_q <= DSZ_EMPTY;
      idx_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (load) hold_q <= skid_data;
    end
  end

`ifdef ADC_DSZ_TLAST_EN
  localparam int WCNT_W = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;

  logic [WCNT_W-1:0] wcnt_q;
  logic              wcnt_last;

  assign wcnt_last    = (wcnt_q == WCNT_W'(PKT_WORDS - 1));
  assign m_axis_tlast = m_axis_tvalid & wcnt_last;

  // Packet boundaries follow output words only; they drift relative to input beats.
  always_ff @(posedge pl_clk or negedge rst) begin
    if (!rst) begin
      wcnt_q <= '0;
    end else if (out_fire) begin
      wcnt_q <= wcnt_last ? '0 : wcnt_q + 1'b1;
    end
  end
`else
  // Unframed stream: no word counter and no end-of-packet marker.
`endif

endmodule

// File: tb/tb_adc_stream_downsizer.sv
// Self-checking bench for adc_stream_downsizer: directed steps plus random traffic against a word-queue model.
module tb_adc_stream_downsizer;
  import adc_pkg::*;

  localparam int RATIO = ADC_RATIO;
  localparam int PKT   = 8;

  logic      pl_clk = 1'b0;
  logic      rst    = 1'b0;
  adc_beat_t s_axis_tdata  = '0;
  logic      s_axis_tvalid = 1'b0;
  logic      s_axis_tready;
  adc_word_t m_axis_tdata;
  logic      m_axis_tvalid;
  logic      m_axis_tready = 1'b0;
`ifdef ADC_DSZ_TLAST_EN
  logic      m_axis_tlast;
`endif

  always #5 pl_clk = ~pl_clk;

  adc_stream_downsizer #(
    .IN_WIDTH  (ADC_IN_W),
    .OUT_WIDTH (ADC_PS_W),
    .PKT_WORDS (PKT)
  ) dut (
    .pl_clk        (pl_clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
`ifdef ADC_DSZ_TLAST_EN
    .m_axis_tlast  (m_axis_tlast),
`endif
    .m_axis_tready (m_axis_tready)
  );

  int        n_cmp = 0;
  int        n_err = 0;
  adc_word_t exp_q[$];
  int        cyc = 0;
  bit        in_fire = 1'b0;
  bit        prev_stall = 1'b0;
  adc_word_t prev_data = '0;
  int        out_words = 0;
  int        first_out = -1;
  int        last_out = -1;
  bit        cur_v = 1'b0;
  adc_beat_t cur_d = '0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic adc_beat_t rand_beat();
    adc_beat_t b;
    for (int i = 0; i < ADC_IN_W / 32; i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  // Model: an accepted beat becomes RATIO words, lowest word first.
  function automatic void push_beat(input adc_beat_t b);
    for (int w = 0; w < RATIO; w++) exp_q.push_back(b[w*ADC_PS_W +: ADC_PS_W]);
  endfunction

  task automatic cycle(input bit vin, input adc_beat_t din, input bit rdy);
    adc_word_t exp_w;
    @(negedge pl_clk);
    s_axis_tvalid = vin;
    s_axis_tdata  = din;
    m_axis_tready = rdy;
    #1;
    cyc++;
    in_fire = vin && (s_axis_tready === 1'b1);
    if (in_fire) push_beat(din);
    if (prev_stall) begin
      chk("stall_valid", m_axis_tvalid, 1'b1);
      chk("stall_data", m_axis_tdata, prev_data);
    end
`ifdef ADC_DSZ_TLAST_EN
    if (m_axis_tvalid === 1'b1) chk("tlast", m_axis_tlast, (out_words % PKT) == PKT - 1);
`endif
    if (m_axis_tvalid === 1'b1 && rdy) begin
      n_cmp++;
      assert (exp_q.size() != 0) else begin
        n_err++;
        $error("FAIL spurious_word: observed %0h expected no word", m_axis_tdata);
      end
      if (exp_q.size() != 0) begin
        exp_w = exp_q.pop_front();
        chk("word", m_axis_tdata, exp_w);
      end
      out_words++;
      if (first_out < 0) first_out = cyc;
      last_out = cyc;
    end
    prev_stall = (m_axis_tvalid === 1'b1) && !rdy;
    prev_data  = m_axis_tdata;
  endtask

  task automatic stream(input int beats, input int vpct, input int rpct, input int max_cyc,
                        input bit drain, output int sent);
    sent = 0;
    for (int c = 0; c < max_cyc; c++) begin
      if (!cur_v && sent < beats && int'($urandom_range(99)) < vpct) begin
        cur_v = 1'b1;
        cur_d = rand_beat();
      end
      cycle(cur_v, cur_d, int'($urandom_range(99)) < rpct);
      if (in_fire) begin
        cur_v = 1'b0;
        sent++;
      end
      if (drain && sent == beats && exp_q.size() == 0) break;
    end
  endtask

  initial begin
    adc_beat_t b1;
    int        sent;
    int        words0;

    // Reset state
    repeat (3) @(negedge pl_clk);
    chk("rst_m_tvalid", m_axis_tvalid, 1'b0);
    chk("rst_m_tdata", m_axis_tdata, '0);
    chk("rst_s_tready", s_axis_tready, 1'b0);
`ifdef ADC_DSZ_TLAST_EN
    chk("rst_m_tlast", m_axis_tlast, 1'b0);
`endif
    rst = 1'b1;
    @(posedge pl_clk);
    #1;
    chk("rel_s_tready", s_axis_tready, 1'b1);

    // Step 1: single beat, latency and word order
    b1 = 128'h44444444_33333333_22222222_11111111;
    cycle(1'b1, b1, 1'b1);
    chk("t1_accept", in_fire, 1'b1);
    cycle(1'b0, '0, 1'b1);
    chk("t1_lat1_valid", m_axis_tvalid, 1'b0);
    cycle(1'b0, '0, 1'b1);
    chk("t1_lat2_valid", m_axis_tvalid, 1'b1);
    chk("t1_word0", m_axis_tdata, 32'h11111111);
    repeat (RATIO - 1) cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1);
    chk("t1_idle_valid", m_axis_tvalid, 1'b0);
    chk("t1_drained", exp_q.size(), 0);

    // Step 2: back-to-back beats, no output bubbles
    words0    = out_words;
    first_out = -1;
    stream(64, 100, 100, 600, 1'b1, sent);
    chk("t2_sent", sent, 64);
    chk("t2_words", out_words - words0, 64 * RATIO);
    chk("t2_no_bubble", last_out - first_out + 1, 64 * RATIO);
    chk("t2_drained", exp_q.size(), 0);

    // Step 3: random valid and ready
    stream(2000, 60, 50, 40000, 1'b1, sent);
    chk("t3_sent", sent, 2000);
    chk("t3_drained", exp_q.size(), 0);

    // Step 4: output stalled with input streaming
    stream(100, 100, 0, 20, 1'b0, sent);
    chk("t4_accepts", sent, 3);
    chk("t4_s_tready", s_axis_tready, 1'b0);
    stream(1, 0, 100, 200, 1'b1, sent);
    chk("t4_pending_sent", sent, 1);
    chk("t4_drained", exp_q.size(), 0);

    // Step 5: reset after 2 of 4 words
    cycle(1'b1, rand_beat(), 1'b1);
    repeat (3) cycle(1'b0, '0, 1'b1);
    chk("t5_words_left", exp_q.size(), RATIO - 2);
    @(negedge pl_clk);
    m_axis_tready = 1'b0;
    rst = 1'b0;
    #1;
    chk("t5_rst_m_tvalid", m_axis_tvalid, 1'b0);
    chk("t5_rst_m_tdata", m_axis_tdata, '0);
    chk("t5_rst_s_tready", s_axis_tready, 1'b0);
    exp_q.delete();
    out_words  = 0;
    prev_stall = 1'b0;
    cur_v      = 1'b0;
    @(negedge pl_clk);
    rst = 1'b1;
    @(posedge pl_clk);
    #1;
    chk("t5_rel_s_tready", s_axis_tready, 1'b1);
    stream(1, 100, 100, 100, 1'b1, sent);
    chk("t5_sent", sent, 1);
    chk("t5_words", out_words, RATIO);

    // Step 6: framed stream; tlast positions are checked on every valid word
    stream(4, 100, 100, 200, 1'b1, sent);
    chk("t6_sent", sent, 4);
    chk("t6_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
